push_control: RTL and testbench
===============================

# push_control

Stack-push sequencer for the pipeline's memory stage, and the counterpart of the return/interrupt pop logic. On a CALL or an accepted interrupt it stalls the pipeline and writes the return PC (and, for interrupts, the flags) to the data-memory stack over several 16-bit write cycles. It then writes back the decremented SP and issues a one-cycle jump request. It sits beside the memory-stage controller and drives the data-memory write port while busy.

## Interface
Parameters:
- `DATA_W`, default 16: data-memory word width.
- `ADDR_W`, default 32: stack-pointer and memory address width.
- `FLAG_W`, default 4: CCR flag width, zero-extended to `DATA_W` when pushed.

Ports:
- `clk`  in  1  single clock, all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `call`  in  1  CALL instruction present in the memory stage this cycle.
- `int`  in  1  external interrupt request; level, sampled each cycle.
- `pc_in`  in  32  return address to push.
- `sp_in`  in  ADDR_W  current stack pointer; points at the first free word.
- `flags_in`  in  FLAG_W  current flags.
- `mem_we`  out  1  data-memory write enable.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `sp_out`  out  ADDR_W  new stack pointer.
- `sp_we`  out  1  SP register write enable, one-cycle pulse.
- `stall`  out  1  freeze the pipeline front-end.
- `jump`  out  1  redirect-PC pulse.
- `jump_sel`  out  1  0 = call target, 1 = interrupt vector.
- `int_ack`  out  1  one-cycle pulse when an interrupt is accepted.

## Operation
- States:
  - `IDLE`: outputs deasserted except as noted below.
  - `PUSH_HI`: write `pc[31:16]` at `sp`.
  - `PUSH_LO`: write `pc[15:0]` at `sp-1`.
  - `PUSH_FLG`: interrupt only; write `{0, flags}` at `sp-2`.
  - `JUMP`: no memory write.
- Acceptance in `IDLE`:
  - `call` takes priority over `int`/pending.
  - On acceptance, latch `pc_in`, `sp_in`, flags and the kind (call/int); next state is `PUSH_HI`.
  - `int_ack` pulses in the cycle an interrupt is accepted.
- Transitions:
  - `PUSH_HI` → `PUSH_LO`.
  - `PUSH_LO` → `PUSH_FLG` if kind is int, else `JUMP`.
  - `PUSH_FLG` → `JUMP`.
  - `JUMP` → `IDLE`.
- `int_pending`:
  - Set when `int` is high and is not accepted this cycle (busy, or losing to `call`).
  - Cleared on interrupt acceptance.
  - In `IDLE`, `int` or `int_pending` counts as a request.
- `stall` is high in every non-`IDLE` state, and combinationally high in the `IDLE` acceptance cycle.
- In `JUMP`:
  - `stall`=0, `jump`=1, `jump_sel`=kind.
  - `sp_we`=1 with `sp_out` = latched sp − 2 (call) or − 3 (int).
- SP/address arithmetic is modulo 2^ADDR_W: sp=0 writes at 0, 0xFFFFFFFF, 0xFFFFFFFE.
- Stack grows downward. The pop side reads flags, then low, then high.

## Timing
- Reset: all outputs 0, state `IDLE`, `int_pending`=0, latched registers 0.
- Call latency: request cycle T, writes at T+1 and T+2, `jump`/`sp_we` at T+3. Stall covers T..T+2.
- Interrupt latency: writes at T+1..T+3, `jump` at T+4.
- Back-to-back:
  - A request present in the cycle after `JUMP` (back in `IDLE`) is accepted there.
  - A pending interrupt starts no earlier than one cycle after the jump.
- Mid-operation reset aborts immediately:
  - No `sp_we` is issued, so the architectural SP is unchanged.
  - Partial stack writes are left in memory.
- `call`/`int`/`pc_in`/`sp_in` are ignored outside `IDLE`, except that `int` sets `int_pending`.

## Structure
- Shared package `mips_pkg`:
  - State encoding constants `PS_IDLE`, `PS_HI`, `PS_LO`, `PS_FLG`, `PS_JUMP`.
  - `JSEL_CALL`/`JSEL_INT`.
  - Push word counts: 2 for call, 3 for int.
- No sub-module.
- One state register, one capture register set, one pending flop.
- Address/data mux is combinational on state.

## Test plan
1. Call, sp=0x0000_0100, pc=0x1234_5678 → writes 0x1234@0x100 and 0x5678@0xFF; `jump`=1, `jump_sel`=0, `sp_out`=0xFE on the third cycle.
2. Interrupt, sp=0x100, flags=0xA → writes 0x1234@0x100, 0x5678@0xFF, 0x000A@0xFE; `int_ack` pulses at T; `sp_out`=0xFD, `jump_sel`=1 at T+4.
3. `call`=`int`=1 together → call sequence runs first; interrupt sequence is accepted the cycle after call `JUMP`, with `int_ack` there.
4. One-cycle `int` pulse during `PUSH_LO` of a call → `int_pending` holds it; interrupt is serviced after the call completes.
5. sp=0x0000_0001, call → writes at 0x1 and 0x0; `sp_out`=0xFFFF_FFFF.
6. `rst` asserted in `PUSH_LO` → all outputs 0 asynchronously; no `sp_we`/`jump`; a subsequent call restarts cleanly from `PUSH_HI`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared memory-stage definitions for the
// stack-push sequencer.
package mips_pkg;

  typedef enum logic [2:0] {
    PS_IDLE = 3'd0,
    PS_HI   = 3'd1,
    PS_LO   = 3'd2,
    PS_FLG  = 3'd3,
    PS_JUMP = 3'd4
  } ps_t;

  localparam logic JSEL_CALL = 1'b0;
  localparam logic JSEL_INT  = 1'b1;

  localparam int PUSH_CALL = 2;
  localparam int PUSH_INT  = 3;

endpackage

// File: rtl/push_control_if.sv
// Push sequencer <-> memory stage bundle:
// requests in, data-memory write port and SP out.
interface push_control_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int FLAG_W = 4
);
  logic              call;
  logic              int_req;
  logic [31:0]       pc_in;
  logic [ADDR_W-1:0] sp_in;
  logic [FLAG_W-1:0] flags_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] sp_out;
  logic              sp_we;
  logic              stall;
  logic              jump;
  logic              jump_sel;
  logic              int_ack;

  modport master (
    output call, int_req, pc_in,
    output sp_in, flags_in,
    input  mem_we, mem_addr, mem_wdata,
    input  sp_out, sp_we, stall,
    input  jump, jump_sel, int_ack
  );

  modport slave (
    input  call, int_req, pc_in,
    input  sp_in, flags_in,
    output mem_we, mem_addr, mem_wdata,
    output sp_out, sp_we, stall,
    output jump, jump_sel, int_ack
  );
endinterface

// File: rtl/push_control.sv
// Stack-push sequencer: pushes return PC (and
// flags on interrupt), then updates SP and jumps.
module push_control
  import mips_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int FLAG_W = 4
) (
  input logic         clk,
  input logic         rst,
  push_control_if.slave bus
);

  ps_t               state;
  logic [31:0]       pc_q;
  logic [ADDR_W-1:0] sp_q;
  logic [FLAG_W-1:0] flg_q;
  logic              kind_q;
  logic              pend_q;

  logic idle;
  logic irq;
  logic acc;
  logic int_acc;

  assign idle    = (state == PS_IDLE);
  assign irq     = bus.int_req | pend_q;
  assign acc     = !rst & idle & (bus.call | irq);
  assign int_acc = acc & !bus.call;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PS_IDLE;
      pc_q   <= '0;
      sp_q   <= '0;
      flg_q  <= '0;
      kind_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (int_acc)
        pend_q <= 1'b0;
      else if (bus.int_req)
        pend_q <= 1'b1;
      unique case (state)
        PS_IDLE: begin
          if (acc) begin
            pc_q   <= bus.pc_in;
            sp_q   <= bus.sp_in;
            flg_q  <= bus.flags_in;
            kind_q <= bus.call ? JSEL_CALL
                               : JSEL_INT;
            state  <= PS_HI;
          end
        end
        PS_HI:  state <= PS_LO;
        PS_LO:  state <= (kind_q == JSEL_INT)
                         ? PS_FLG : PS_JUMP;
        PS_FLG: state <= PS_JUMP;
        PS_JUMP: state <= PS_IDLE;
        default: state <= PS_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.sp_out    = '0;
    bus.sp_we     = 1'b0;
    bus.stall     = 1'b0;
    bus.jump      = 1'b0;
    bus.jump_sel  = 1'b0;
    bus.int_ack   = 1'b0;
    unique case (state)
      PS_IDLE: begin
        bus.stall   = acc;
        bus.int_ack = int_acc;
      end
      PS_HI: begin
        bus.stall     = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = sp_q;
        bus.mem_wdata = DATA_W'(pc_q[31:16]);
      end
      PS_LO: begin
        bus.stall     = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = sp_q - ADDR_W'(1);
        bus.mem_wdata = DATA_W'(pc_q[15:0]);
      end
      PS_FLG: begin
        bus.stall     = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = sp_q - ADDR_W'(2);
        bus.mem_wdata = DATA_W'(flg_q);
      end
      PS_JUMP: begin
        bus.jump     = 1'b1;
        bus.jump_sel = kind_q;
        bus.sp_we    = 1'b1;
        // SP ends just below the last pushed word
        bus.sp_out   = sp_q - ((kind_q == JSEL_INT)
                       ? ADDR_W'(PUSH_INT)
                       : ADDR_W'(PUSH_CALL));
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_push_control.sv
// Directed self-checking bench for push_control.
module tb_push_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  push_control_if #(16, 32, 4) bus ();

  push_control #(
    .DATA_W(16), .ADDR_W(32), .FLAG_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(
    input string tag,
    input logic we, input logic [31:0] addr,
    input logic [15:0] wd, input logic spwe,
    input logic [31:0] spo, input logic st,
    input logic jp, input logic js,
    input logic ack);
    chk({tag, ".we"},    32'(bus.mem_we), 32'(we));
    chk({tag, ".addr"},  bus.mem_addr, addr);
    chk({tag, ".wdata"}, 32'(bus.mem_wdata), 32'(wd));
    chk({tag, ".sp_we"}, 32'(bus.sp_we), 32'(spwe));
    chk({tag, ".sp_out"}, bus.sp_out, spo);
    chk({tag, ".stall"}, 32'(bus.stall), 32'(st));
    chk({tag, ".jump"},  32'(bus.jump), 32'(jp));
    chk({tag, ".jsel"},  32'(bus.jump_sel), 32'(js));
    chk({tag, ".ack"},   32'(bus.int_ack), 32'(ack));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic i,
                       input logic [31:0] pc,
                       input logic [31:0] sp,
                       input logic [3:0] fl);
    bus.call     = c;
    bus.int_req  = i;
    bus.pc_in    = pc;
    bus.sp_in    = sp;
    bus.flags_in = fl;
    #1;
  endtask

  localparam logic [31:0] X = 32'hDEAD_BEEF;

  initial begin
    drive(0, 0, 0, 0, 0);
    chk_all("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h1234_5678, 32'h100, 4'hA);
    chk_all("rst_in", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // 1: call
    drive(1, 0, 32'h1234_5678, 32'h100, 4'h3);
    chk_all("c.T", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, X, X, 4'h5);
    chk_all("c.hi", 1, 32'h100, 16'h1234,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("c.lo", 1, 32'hFF, 16'h5678,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("c.jmp", 0, 0, 0, 1, 32'hFE,
            0, 1, 0, 0);
    tick();
    chk_all("c.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 2: interrupt
    drive(0, 1, 32'h1234_5678, 32'h100, 4'hA);
    chk_all("i.T", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tick();
    drive(0, 0, X, X, 4'h5);
    chk_all("i.hi", 1, 32'h100, 16'h1234,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("i.lo", 1, 32'hFF, 16'h5678,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("i.flg", 1, 32'hFE, 16'h000A,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("i.jmp", 0, 0, 0, 1, 32'hFD,
            0, 1, 1, 0);
    tick();
    chk_all("i.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 3: call and int together
    drive(1, 1, 32'h1111_2222, 32'h80, 4'h6);
    chk_all("b.T", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, X, X, 4'h0);
    chk_all("b.hi", 1, 32'h80, 16'h1111,
            0, 0, 1, 0, 0, 0);
    tick();
    tick();
    chk_all("b.jmp", 0, 0, 0, 1, 32'h7E,
            0, 1, 0, 0);
    tick();
    drive(0, 0, 32'hAAAA_5555, 32'h200, 4'h9);
    chk_all("b.acc", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tick();
    drive(0, 0, X, X, 4'h0);
    chk_all("b.hi2", 1, 32'h200, 16'hAAAA,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("b.lo2", 1, 32'h1FF, 16'h5555,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("b.flg2", 1, 32'h1FE, 16'h0009,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("b.jmp2", 0, 0, 0, 1, 32'h1FD,
            0, 1, 1, 0);
    tick();

    // 4: int pulse during PUSH_LO
    drive(1, 0, 32'h0000_4444, 32'h40, 4'h1);
    tick();
    drive(0, 0, X, X, 4'h0);
    tick();
    drive(0, 1, X, X, 4'h0);
    chk_all("p.lo", 1, 32'h3F, 16'h4444,
            0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 32'h0000_7777, 32'h300, 4'h2);
    chk_all("p.jmp", 0, 0, 0, 1, 32'h3E,
            0, 1, 0, 0);
    tick();
    chk_all("p.acc", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tick();
    drive(0, 0, X, X, 4'h0);
    chk_all("p.hi", 1, 32'h300, 16'h0000,
            0, 0, 1, 0, 0, 0);
    tick();
    tick();
    chk_all("p.flg", 1, 32'h2FE, 16'h0002,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("p.jmp2", 0, 0, 0, 1, 32'h2FD,
            0, 1, 1, 0);
    tick();
    chk_all("p.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 5: SP wrap
    drive(1, 0, 32'hCAFE_F00D, 32'h1, 4'h0);
    tick();
    drive(0, 0, X, X, 4'h0);
    chk_all("w.hi", 1, 32'h1, 16'hCAFE,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("w.lo", 1, 32'h0, 16'hF00D,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("w.jmp", 0, 0, 0, 1, 32'hFFFF_FFFF,
            0, 1, 0, 0);
    tick();
    drive(0, 1, 32'h0001_0002, 32'h0, 4'hF);
    tick();
    drive(0, 0, X, X, 4'h0);
    tick();
    chk_all("w.lo0", 1, 32'hFFFF_FFFF, 16'h0002,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("w.flg0", 1, 32'hFFFF_FFFE, 16'h000F,
            0, 0, 1, 0, 0, 0);
    tick();
    chk_all("w.jmp0", 0, 0, 0, 1, 32'hFFFF_FFFD,
            0, 1, 1, 0);
    tick();

    // 6: reset mid-push
    drive(1, 0, 32'h5A5A_A5A5, 32'h500, 4'h0);
    tick();
    drive(0, 0, X, X, 4'h0);
    tick();
    chk_all("r.lo", 1, 32'h4FF, 16'hA5A5,
            0, 0, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk_all("r.async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_all("r.after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h0BAD_0F0F, 32'h600, 4'h0);
    chk_all("r.T", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, X, X, 4'h0);
    chk_all("r.hi", 1, 32'h600, 16'h0BAD,
            0, 0, 1, 0, 0, 0);
    tick();
    tick();
    chk_all("r.jmp", 0, 0, 0, 1, 32'h5FE,
            0, 1, 0, 0);
    tick();

    $display("%0d/%0d checks passed",
             total - fails, total);
    $finish;
  end

endmodule
